micro_sequencer: RTL and testbench

Microprogram sequencer for the multicycle MIPS control unit, and the consumer of the instruction encoder's 7-bit `State_Sel` output. Each cycle it holds the current control-ROM state number and computes the next one from the sequencing field of the current microinstruction: increment, decode dispatch, jump, conditional branch, memory-wait, or return to fetch. It also enforces a memory-wait timeout, traps illegal sequencing codes into a fault state, and counts decoded instructions.

---
 rtl/micro_sequencer.sv | 100 ++++++++++
 tb/tb_micro_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the control-ROM state number and selects the next one
// from the microinstruction's sequencing mode, with memory-wait timeout and fault capture.
module micro_sequencer #(
    parameter logic [6:0] FETCH_STATE = 7'd1,
    parameter logic [6:0] FAULT_STATE = 7'd127,
    parameter logic [7:0] TIMEOUT     = 8'd15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [6:0]  State_Sel,
    input  logic [2:0]  N_Sel,
    input  logic [6:0]  Cr_Addr,
    input  logic        Inv,
    input  logic        Cond,
    input  logic        MOC,
    output logic [6:0]  State,
    output logic        Stall,
    output logic [1:0]  Fault,
    output logic [15:0] Instr_Count
);

    typedef enum logic [2:0] {
        MODE_INCR   = 3'd0,
        MODE_DECODE = 3'd1,
        MODE_JUMP   = 3'd2,
        MODE_COND   = 3'd3,
        MODE_WAIT   = 3'd4,
        MODE_FETCH  = 3'd5,
        MODE_ILL6   = 3'd6,
        MODE_ILL7   = 3'd7
    } mode_e;

    mode_e       mode;
    logic [6:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic [6:0]  state_inc;

    assign mode      = mode_e'(N_Sel);
    assign state_inc = state_q + 7'd1;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        fault_d       = fault_q;
        instr_count_d = instr_count_q;
        unique case (mode)
            MODE_INCR:   state_d = state_inc;
            MODE_DECODE: begin
                state_d       = State_Sel;
                instr_count_d = instr_count_q + 16'd1;
            end
            MODE_JUMP:   state_d = Cr_Addr;
            MODE_COND:   state_d = (Cond ^ Inv) ? Cr_Addr : state_inc;
            MODE_WAIT: begin
                // MOC wins over an expiring timeout on the same edge
                if (MOC) begin
                    state_d = Cr_Addr;
                end else if (TIMEOUT != 8'd0) begin
                    if (wait_cnt_q == TIMEOUT - 8'd1) begin
                        state_d    = FAULT_STATE;
                        fault_d[0] = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            MODE_FETCH:  state_d = FETCH_STATE;
            MODE_ILL6, MODE_ILL7: begin
                state_d    = FAULT_STATE;
                fault_d[1] = 1'b1;
            end
            default: begin
                state_d    = FAULT_STATE;
                fault_d[1] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= '0;
            wait_cnt_q    <= '0;
            fault_q       <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign State       = state_q;
    assign Fault       = fault_q;
    assign Instr_Count = instr_count_q;
    assign Stall       = (mode == MODE_WAIT) && !MOC;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed sequences plus randomized bursts, scored against
// a behavioural model through an expectation queue drained by an independent monitor.
module tb_micro_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [6:0]  State_Sel;
    logic [2:0]  N_Sel;
    logic [6:0]  Cr_Addr;
    logic        Inv;
    logic        Cond;
    logic        MOC;
    logic [6:0]  State;
    logic        Stall;
    logic [1:0]  Fault;
    logic [15:0] Instr_Count;

    micro_sequencer #(
        .FETCH_STATE(7'd1),
        .FAULT_STATE(7'd127),
        .TIMEOUT    (8'd15)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .State_Sel  (State_Sel),
        .N_Sel      (N_Sel),
        .Cr_Addr    (Cr_Addr),
        .Inv        (Inv),
        .Cond       (Cond),
        .MOC        (MOC),
        .State      (State),
        .Stall      (Stall),
        .Fault      (Fault),
        .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        stall;
        logic [6:0]  st;
        logic [1:0]  flt;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: plain integers, wait tracked as cycles already spent waiting
    int          m_state = 0;
    int          m_cnt   = 0;
    int          m_waited = 0;
    logic [1:0]  m_fault = 2'b00;
    localparam int TO = 15;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one microinstruction now, advance the model, queue the expectation.
    task automatic apply(input int nsel, input int sel, input int cr,
                         input bit inv, input bit cond, input bit moc);
        exp_t e;
        int   ns;
        N_Sel     = 3'(nsel);
        State_Sel = 7'(sel);
        Cr_Addr   = 7'(cr);
        Inv       = inv;
        Cond      = cond;
        MOC       = moc;
        e.stall   = (nsel == 4) && !moc;
        ns        = m_state;
        if (nsel != 4) m_waited = 0;
        case (nsel)
            0: ns = (m_state + 1) % 128;
            1: begin ns = sel; m_cnt = (m_cnt + 1) % 65536; end
            2: ns = cr;
            3: ns = (cond != inv) ? cr : (m_state + 1) % 128;
            4: begin
                if (moc) begin
                    ns = cr;
                    m_waited = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        ns = 127;
                        m_fault[0] = 1'b1;
                        m_waited = 0;
                    end
                end
            end
            5: ns = 1;
            default: begin ns = 127; m_fault[1] = 1'b1; end
        endcase
        m_state = ns;
        e.st    = 7'(m_state);
        e.flt   = m_fault;
        e.cnt   = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic step(input int nsel, input int sel, input int cr,
                        input bit inv, input bit cond, input bit moc);
        apply(nsel, sel, cr, inv, cond, moc);
        @(negedge Clk);
    endtask

    // Asynchronous reset between edges; the following edge runs INCR from state 0.
    task automatic pulse_reset();
        #1 Reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(State), 32'd0);
        chk("async_reset_fault", 32'(Fault), 32'd0);
        chk("async_reset_count", 32'(Instr_Count), 32'd0);
        Reset    = 1'b0;
        m_state  = 0;
        m_cnt    = 0;
        m_waited = 0;
        m_fault  = 2'b00;
        #1;
        apply(0, 0, 0, 0, 0, 0);
        @(negedge Clk);
    endtask

    // Monitor: Stall sampled late in the low phase, registers just after the edge.
    initial begin
        exp_t e;
        logic stall_s;
        forever begin
            @(negedge Clk);
            #4 stall_s = Stall;
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(stall_s), 32'(e.stall));
                chk("state", 32'(State), 32'(e.st));
                chk("fault", 32'(Fault), 32'(e.flt));
                chk("instr_count", 32'(Instr_Count), 32'(e.cnt));
            end
        end
    end

    initial begin
        Reset = 1'b1;
        N_Sel = 3'd0; State_Sel = '0; Cr_Addr = '0; Inv = 1'b0; Cond = 1'b0; MOC = 1'b0;
        #7;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_fault", 32'(Fault), 32'd0);
        chk("reset_count", 32'(Instr_Count), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk("incr_three", 32'(State), 32'd3);
        step(2, 0, 127, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("incr_wrap", 32'(State), 32'd0);
        step(2, 0, 55, 0, 0, 0);
        pulse_reset();

        step(1, 13, 0, 0, 0, 0);
        chk("decode_lw_state", 32'(State), 32'd13);
        chk("decode_lw_count", 32'(Instr_Count), 32'd1);

        step(3, 0, 40, 0, 1, 0);
        chk("cond_taken", 32'(State), 32'd40);
        step(3, 0, 40, 1, 1, 0);
        chk("cond_inv_not_taken", 32'(State), 32'd41);
        step(3, 0, 40, 1, 0, 0);
        chk("cond_inv_taken", 32'(State), 32'd40);

        step(2, 0, 20, 0, 0, 0);
        repeat (3) step(4, 0, 14, 0, 0, 0);
        chk("wait_hold", 32'(State), 32'd20);
        step(4, 0, 14, 0, 0, 1);
        chk("wait_exit", 32'(State), 32'd14);
        chk("wait_exit_fault", 32'(Fault), 32'd0);

        repeat (15) step(4, 0, 14, 0, 0, 0);
        chk("timeout_state", 32'(State), 32'd127);
        chk("timeout_fault", 32'(Fault), 32'd1);
        pulse_reset();
        repeat (14) step(4, 0, 33, 0, 0, 0);
        step(4, 0, 33, 0, 0, 1);
        chk("late_moc_state", 32'(State), 32'd33);
        chk("late_moc_fault", 32'(Fault), 32'd0);
        step(2, 0, 9, 0, 0, 0);
        repeat (4) step(4, 0, 10, 0, 0, 0);
        step(2, 0, 50, 0, 0, 0);
        repeat (15) step(4, 0, 10, 0, 0, 0);
        chk("wait_restart_fault", 32'(Fault), 32'd1);
        pulse_reset();

        step(6, 0, 0, 0, 0, 0);
        chk("illegal_state", 32'(State), 32'd127);
        chk("illegal_fault", 32'(Fault), 32'd2);
        step(5, 0, 0, 0, 0, 0);
        chk("fetch_state", 32'(State), 32'd1);
        chk("fault_sticky", 32'(Fault), 32'd2);
        step(7, 0, 0, 0, 0, 0);
        pulse_reset();

        for (int i = 0; i < 65536; i++) step(1, int'($urandom_range(0, 127)), 0, 0, 0, 0);
        chk("count_wrap", 32'(Instr_Count), 32'd0);
        pulse_reset();

        for (int b = 0; b < 300; b++) begin
            int r    = int'($urandom_range(0, 99));
            int mode = (r < 4) ? 6 + int'($urandom_range(0, 1)) :
                       (r < 40) ? 4 : int'($urandom_range(0, 5));
            int len  = int'($urandom_range(1, 20));
            int cr   = int'($urandom_range(0, 127));
            for (int k = 0; k < len; k++)
                step(mode, int'($urandom_range(0, 127)), cr, 1'($urandom),
                     1'($urandom), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 30) == 0) pulse_reset();
        end

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
